// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared types and constants for the MEM pipeline stage
//
// Purpose : word/register widths, MEM/WB register layout, data-memory FSM
//           state encoding and the address alignment helper.
// Ports   : none (package).
package memory_stage_pkg;

  localparam int WORD_W         = 32;
  localparam int REG_SIZE       = 5;
  localparam int MEMWB_REG_SIZE = WORD_W + REG_SIZE + 3;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]   result;
    logic [REG_SIZE-1:0] write_reg;
    logic                reg_write;
    logic                finish;
    logic                bus_err;
  } memwb_t;

  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/memory_stage_dmem_fsm.sv
// rtl/memory_stage_dmem_fsm.sv - data-memory handshake FSM for the MEM stage
//
// Purpose : sequences one req/ack access on the data-memory bus, generates the
//           pipeline stall while an access is outstanding, and (optionally)
//           abandons an access that never gets acked.
// Macro   : MEMORY_TIMEOUT_EN enables the WAIT-state timeout counter.
// Ports   :
//   clk, reset      clock, synchronous active-high reset
//   mem_op          current EX/MEM instruction is a load or store
//   aligned         its address is word aligned
//   ack             bus acknowledge
//   req             bus request (gated low during reset)
//   stall           freeze the front of the pipeline (gated low during reset)
//   done            the access completes this cycle
//   timeout         the access is abandoned this cycle
module dmem_fsm
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic aligned,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic done,
  output logic timeout
);

  if (2**CNT_W <= TIMEOUT) begin : g_cfg_check
    $error("dmem_fsm: CNT_W too narrow for TIMEOUT");
  end

  mem_state_t state;
  mem_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef MEMORY_TIMEOUT_EN
  // Counts completed WAIT cycles; restarts at zero on every entry to WAIT.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || state != WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          req = 1'b1;
          if (ack) begin
            done = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MEMORY_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT)) begin
          req       = 1'b0;
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
`endif
        else begin
          stall = 1'b1;
        end
      end
    endcase
    // A reset mid-access abandons it immediately: nothing more goes on the bus.
    if (reset) begin
      req     = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage: data-memory access, branch resolve, MEM/WB register
//
// Purpose : consumes the EX/MEM register, drives the data-memory req/ack bus,
//           stalls the front of the pipeline during wait states, resolves the
//           branch and loads the MEM/WB register.
// Macro   : MEMORY_TIMEOUT_EN enables the bus timeout inside dmem_fsm.
// Ports   :
//   clk, reset                     clock, synchronous active-high reset
//   writeDataM/ALUResultM/pcM      store data, address/ALU result, PC
//   writeRegM, regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM
//                                  EX/MEM control
//   dmem_req/we/addr/wdata         data-memory request side
//   dmem_ack/rdata                 data-memory response side
//   stallM                         freeze PC, IF/ID, ID/EX, EX/MEM
//   pcSrcM, branchPcM              branch decision and target
//   resultW, writeRegW, regWriteW, finishW, busErrW   MEM/WB register
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   writeDataM,
  input  logic [WORD_W-1:0]   ALUResultM,
  input  logic [WORD_W-1:0]   pcM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic                zeroM,
  input  logic                branchM,
  input  logic                finishM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_W-1:0]   dmem_addr,
  output logic [WORD_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WORD_W-1:0]   dmem_rdata,
  output logic                stallM,
  output logic                pcSrcM,
  output logic [WORD_W-1:0]   branchPcM,
  output logic [WORD_W-1:0]   resultW,
  output logic [REG_SIZE-1:0] writeRegW,
  output logic                regWriteW,
  output logic                finishW,
  output logic                busErrW
);

  logic   mem_op;
  logic   aligned;
  logic   misaligned;
  logic   is_load;
  logic   done;
  logic   timeout;
  memwb_t memwb_d;
  memwb_t memwb_q;

  assign mem_op     = memWriteM | mem2regM;
  assign aligned    = is_aligned(ALUResultM);
  assign misaligned = mem_op & ~aligned;
  // With both controls set the instruction is a store, never a load.
  assign is_load    = mem2regM & ~memWriteM;

  dmem_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dmem_fsm (
    .clk     (clk),
    .reset   (reset),
    .mem_op  (mem_op),
    .aligned (aligned),
    .ack     (dmem_ack),
    .req     (dmem_req),
    .stall   (stallM),
    .done    (done),
    .timeout (timeout)
  );

  // Upstream registers are frozen while stalled, so these stay stable in WAIT.
  assign dmem_we    = memWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = writeDataM;

  assign pcSrcM    = branchM & zeroM & ~stallM & ~reset;
  assign branchPcM = pcM;

  always_comb begin
    memwb_d = '0;
    if (!stallM) begin
      memwb_d.result    = (is_load && done) ? dmem_rdata : ALUResultM;
      memwb_d.write_reg = writeRegM;
      memwb_d.finish    = finishM;
      memwb_d.bus_err   = misaligned | timeout;
      memwb_d.reg_write = regWriteM & ~memWriteM & ~(misaligned | timeout);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign resultW   = memwb_q.result;
  assign writeRegW = memwb_q.write_reg;
  assign regWriteW = memwb_q.reg_write;
  assign finishW   = memwb_q.finish;
  assign busErrW   = memwb_q.bus_err;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writeDataM, ALUResultM, pcM;
  logic [4:0]  writeRegM;
  logic        regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stallM, pcSrcM;
  logic [31:0] branchPcM, resultW;
  logic [4:0]  writeRegW;
  logic        regWriteW, finishW, busErrW;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM),
    .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
    .mem2regM(mem2regM), .zeroM(zeroM), .branchM(branchM), .finishM(finishM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stallM(stallM), .pcSrcM(pcSrcM), .branchPcM(branchPcM),
    .resultW(resultW), .writeRegW(writeRegW), .regWriteW(regWriteW),
    .finishW(finishW), .busErrW(busErrW)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_nop();
    writeDataM = $urandom; ALUResultM = $urandom; pcM = $urandom;
    writeRegM = 5'($urandom); regWriteM = 0; memWriteM = 0; mem2regM = 0;
    zeroM = 0; branchM = 0; finishM = 0; dmem_ack = 0; dmem_rdata = $urandom;
  endtask

  task automatic test_reset();
    reset = 1; set_nop(); branchM = 1; zeroM = 1; regWriteM = 1; finishM = 1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({resultW, writeRegW, regWriteW, finishW, busErrW} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_w got %h exp 0", {resultW, writeRegW, regWriteW, finishW, busErrW});
    end
    tests_run++;
    if ({dmem_req, stallM, pcSrcM} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_gate req/stall/pcsrc got %b exp 000", {dmem_req, stallM, pcSrcM});
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    set_nop(); mem2regM = 1; regWriteM = 1; ALUResultM = 32'h10; writeRegM = 5'd7;
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    tests_run++;
    if ({dmem_req, dmem_we, stallM, dmem_addr} !== {3'b100, 32'h10}) begin
      tests_failed++;
      $display("FAIL zw_bus req/we/stall/addr got %b%b%b %h exp 100 10", dmem_req, dmem_we, stallM, dmem_addr);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({resultW, writeRegW, regWriteW, busErrW} !== {32'hDEADBEEF, 5'd7, 2'b10}) begin
      tests_failed++;
      $display("FAIL zw_w got %h %0d %b %b exp deadbeef 7 1 0", resultW, writeRegW, regWriteW, busErrW);
    end
  endtask

  task automatic test_store_wait3();
    int stall_cnt = 0;
    @(negedge clk);
    set_nop(); memWriteM = 1; regWriteM = 1; ALUResultM = 32'h20; writeDataM = 32'h55; finishM = 1;
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      #1;
      tests_run++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 32'h20, 32'h55}) begin
        tests_failed++;
        $display("FAIL st3_bus c%0d got %b%b %h %h exp 11 20 55", c, dmem_req, dmem_we, dmem_addr, dmem_wdata);
      end
      if (stallM) stall_cnt++;
      @(posedge clk); #1;
      if (c < 3) begin
        tests_run++;
        if ({regWriteW, finishW, busErrW} !== 3'b000) begin
          tests_failed++;
          $display("FAIL st3_bubble c%0d got %b exp 000", c, {regWriteW, finishW, busErrW});
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (stall_cnt != 3) begin
      tests_failed++;
      $display("FAIL st3_stallcnt got %0d exp 3", stall_cnt);
    end
    tests_run++;
    if ({regWriteW, finishW, busErrW} !== 3'b010) begin
      tests_failed++;
      $display("FAIL st3_w regw/fin/err got %b exp 010", {regWriteW, finishW, busErrW});
    end
    set_nop();
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_nop(); branchM = 1; zeroM = 1; pcM = 32'h40;
    #1;
    tests_run++;
    if ({pcSrcM, branchPcM} !== {1'b1, 32'h40}) begin
      tests_failed++;
      $display("FAIL br_taken got %b %h exp 1 40", pcSrcM, branchPcM);
    end
    zeroM = 0;
    #1;
    tests_run++;
    if (pcSrcM !== 1'b0) begin
      tests_failed++;
      $display("FAIL br_nz got %b exp 0", pcSrcM);
    end
    // A branch held behind an outstanding load must not redirect the PC yet.
    zeroM = 1; mem2regM = 1; ALUResultM = 32'h44;
    #1;
    tests_run++;
    if ({stallM, pcSrcM} !== 2'b10) begin
      tests_failed++;
      $display("FAIL br_stalled stall/pcsrc got %b exp 10", {stallM, pcSrcM});
    end
    @(negedge clk);
    dmem_ack = 1;
    #1;
    tests_run++;
    if ({stallM, pcSrcM} !== 2'b01) begin
      tests_failed++;
      $display("FAIL br_release stall/pcsrc got %b exp 01", {stallM, pcSrcM});
    end
    @(posedge clk);
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_nop(); mem2regM = 1; regWriteM = 1; ALUResultM = 32'h13;
    #1;
    tests_run++;
    if ({dmem_req, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mis_bus req/stall got %b exp 00", {dmem_req, stallM});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busErrW, regWriteW} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mis_w err/regw got %b exp 10", {busErrW, regWriteW});
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    set_nop(); mem2regM = 1; regWriteM = 1; ALUResultM = 32'h30;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1;
    #1;
    tests_run++;
    if ({dmem_req, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rmw_gate req/stall got %b exp 00", {dmem_req, stallM});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({resultW, writeRegW, regWriteW, finishW, busErrW} !== 40'h0) begin
      tests_failed++;
      $display("FAIL rmw_w got %h exp 0", {resultW, writeRegW, regWriteW, finishW, busErrW});
    end
    @(negedge clk);
    reset = 0; set_nop();
    #1;
    tests_run++;
    if ({dmem_req, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rmw_idle req/stall got %b exp 00", {dmem_req, stallM});
    end
  endtask

`ifdef MEMORY_TIMEOUT_EN
  task automatic test_timeout();
    int stall_cycles = 0;
    @(negedge clk);
    set_nop(); mem2regM = 1; regWriteM = 1; ALUResultM = 32'h50;
    for (int c = 0; c < 40 && (c == 0 || stallM); c++) begin
      #1;
      if (stallM) stall_cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    // Stalled in IDLE plus 15 WAIT cycles; the abandoning cycle itself is not stalled.
    tests_run++;
    if (stall_cycles != 16) begin
      tests_failed++;
      $display("FAIL to_stall got %0d exp 16", stall_cycles);
    end
    #1;
    tests_run++;
    if ({dmem_req, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL to_drop req/stall got %b exp 00", {dmem_req, stallM});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busErrW, regWriteW} !== 2'b10) begin
      tests_failed++;
      $display("FAIL to_w err/regw got %b exp 10", {busErrW, regWriteW});
    end
    @(negedge clk);
    set_nop(); regWriteM = 1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    tests_run++;
    if ({dmem_req, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL to_late req/stall got %b exp 00", {dmem_req, stallM});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({resultW, regWriteW, busErrW} !== {ALUResultM, 2'b10}) begin
      tests_failed++;
      $display("FAIL to_late_w got %h %b%b exp %h 10", resultW, regWriteW, busErrW, ALUResultM);
    end
    @(negedge clk);
    set_nop();
  endtask
`endif

  // Reference: a word access holds the stage for exactly n_wait extra cycles,
  // anything else retires in one; W carries the retiring instruction's result.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int          kind, n_wait, cycles;
      logic        access, bad, exp_stall, exp_pcsrc;
      logic [31:0] exp_result, rdata_final;
      logic [39:0] exp_w;
      @(negedge clk);
      set_nop();
      kind = $urandom_range(0, 3);
      memWriteM = (kind == 2 || kind == 3);
      mem2regM  = (kind == 1 || kind == 3);
      regWriteM = 1'($urandom); finishM = 1'($urandom);
      branchM = 1'($urandom); zeroM = 1'($urandom);
      if ($urandom_range(0, 4) != 0) ALUResultM[1:0] = 2'b00;
      n_wait = $urandom_range(0, 3);
      access = (memWriteM || mem2regM) && (ALUResultM % 4 == 0);
      bad    = (memWriteM || mem2regM) && (ALUResultM % 4 != 0);
      cycles = access ? n_wait + 1 : 1;
      rdata_final = 32'h0;
      for (int c = 0; c < cycles; c++) begin
        if (c > 0) @(negedge clk);
        dmem_rdata = $urandom;
        dmem_ack   = access ? (c == n_wait) : 1'($urandom);
        rdata_final = dmem_rdata;
        exp_stall = access && (c < n_wait);
        exp_pcsrc = branchM && zeroM && !exp_stall;
        #1;
        tests_run++;
        if ({dmem_req, stallM, pcSrcM, branchPcM} !== {access, exp_stall, exp_pcsrc, pcM}) begin
          tests_failed++;
          $display("FAIL rnd_ctl i%0d c%0d req/stall/pcsrc got %b%b%b exp %b%b%b",
                   i, c, dmem_req, stallM, pcSrcM, access, exp_stall, exp_pcsrc);
        end
        if (access) begin
          tests_run++;
          if ({dmem_we, dmem_addr, dmem_wdata} !== {memWriteM, ALUResultM, writeDataM}) begin
            tests_failed++;
            $display("FAIL rnd_bus i%0d c%0d got %b %h %h exp %b %h %h", i, c,
                     dmem_we, dmem_addr, dmem_wdata, memWriteM, ALUResultM, writeDataM);
          end
        end
        @(posedge clk); #1;
        if (exp_stall) begin
          tests_run++;
          if ({regWriteW, finishW, busErrW} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rnd_bubble i%0d c%0d got %b exp 000", i, c, {regWriteW, finishW, busErrW});
          end
        end
      end
      exp_result = (access && mem2regM && !memWriteM) ? rdata_final : ALUResultM;
      exp_w = {exp_result, writeRegM, regWriteM && !memWriteM && !bad, finishM, bad};
      tests_run++;
      if ({resultW, writeRegW, regWriteW, finishW, busErrW} !== exp_w) begin
        tests_failed++;
        $display("FAIL rnd_w i%0d kind%0d got %h exp %h", i, kind,
                 {resultW, writeRegW, regWriteW, finishW, busErrW}, exp_w);
      end
    end
    @(negedge clk);
    set_nop();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait3();
    test_branch();
    test_misaligned();
    test_reset_mid_wait();
`ifdef MEMORY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
